// File: rtl/hdc_ctrl_pkg.sv
// Shared state type and sizing helpers for the HDC fusion sequencing controller.
package hdc_ctrl_pkg;

  localparam int DEF_HV_DIMENSION = 2000;
  localparam int DEF_WORD_WIDTH   = 32;
  localparam int CREDIT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_RUN,
    ST_DRAIN
  } ctrl_state_t;

  function automatic int calc_nwords(input int hv_dim, input int word_w);
    return (hv_dim + word_w - 1) / word_w;
  endfunction

  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NWORDS = calc_nwords(DEF_HV_DIMENSION, DEF_WORD_WIDTH);
  localparam int DEF_IDX_W  = calc_idx_w(DEF_NWORDS);

endpackage

// File: rtl/hdc_seed_assembler.sv
// Word index and seed register: places each accepted configuration word into its slot
// of the seed hypervector, dropping any bits of the final word beyond the hypervector.
module hdc_seed_assembler
  import hdc_ctrl_pkg::*;
#(
  parameter int HV_DIMENSION = DEF_HV_DIMENSION,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int NWORDS       = DEF_NWORDS,
  parameter int IDX_W        = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_idx,
  input  logic                    wr_en,
  input  logic [WORD_WIDTH-1:0]   word,
  output logic [HV_DIMENSION-1:0] seed_hv,
  output logic                    last_word
);

  logic [IDX_W-1:0]        idx;
  logic [HV_DIMENSION-1:0] seed_next;

  assign last_word = (idx == IDX_W'(NWORDS - 1));

  // The last slot may be narrower than a word; only its low bits are kept.
  for (genvar k = 0; k < NWORDS; k++) begin : g_slot
    localparam int LO = k * WORD_WIDTH;
    localparam int W  = (HV_DIMENSION - LO < WORD_WIDTH) ? (HV_DIMENSION - LO) : WORD_WIDTH;
    assign seed_next[LO +: W] = (wr_en && idx == IDX_W'(k)) ? word[W-1:0] : seed_hv[LO +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      seed_hv <= '0;
    end else begin
      seed_hv <= seed_next;
      if (clear_idx)
        idx <= '0;
      else if (wr_en)
        idx <= last_word ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/hdc_fusion_ctrl.sv
// Sequencing controller in front of the HDC fusion core: seed loading, sample gating,
// in-flight credit tracking, drain-before-reload and result timeout detection.
module hdc_fusion_ctrl
  import hdc_ctrl_pkg::*;
#(
  parameter int HV_DIMENSION   = DEF_HV_DIMENSION,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int MAX_INFLIGHT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [WORD_WIDTH-1:0]   cfg_word,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [HV_DIMENSION-1:0] seed_hv,
  output logic                    seed_hv_valid,
  input  logic                    s_fin_valid,
  output logic                    s_fin_ready,
  output logic                    m_fin_valid,
  input  logic                    m_fin_ready,
  input  logic                    res_valid,
  input  logic                    res_ready,
  output logic                    seed_loaded,
  output logic                    busy,
  output logic [CREDIT_W-1:0]     inflight,
  output logic                    timeout_err,
  output logic                    protocol_err
);

  localparam int NWORDS = calc_nwords(HV_DIMENSION, WORD_WIDTH);
  localparam int IDX_W  = calc_idx_w(NWORDS);
  localparam int TO_W   = calc_idx_w(TIMEOUT_CYCLES);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(MAX_INFLIGHT);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t     state;
  logic [TO_W-1:0] to_cnt;
  logic credit_free, inc, dec, to_fire;
  logic word_accept, last_word, clear_idx, start_clears;

  assign credit_free  = (inflight < MAX_CREDIT);
  assign cfg_ready    = (state == ST_LOAD);
  assign busy         = state inside {ST_LOAD, ST_COMMIT, ST_DRAIN};
  assign m_fin_valid  = (state == ST_RUN) && s_fin_valid && credit_free;
  assign s_fin_ready  = (state == ST_RUN) && m_fin_ready && credit_free;
  assign inc          = m_fin_valid && m_fin_ready;
  assign dec          = res_valid && res_ready;
  assign to_fire      = (inflight != '0) && !dec && (to_cnt == TO_LAST);
  // A restart request wins over a word presented in the same cycle.
  assign word_accept  = cfg_ready && cfg_valid && !cfg_start;
  assign clear_idx    = (cfg_start && state inside {ST_IDLE, ST_LOAD})
                     || (state == ST_DRAIN && inflight == '0);
  assign start_clears = cfg_start && state inside {ST_IDLE, ST_LOAD, ST_RUN};

  hdc_seed_assembler #(
    .HV_DIMENSION (HV_DIMENSION),
    .WORD_WIDTH   (WORD_WIDTH),
    .NWORDS       (NWORDS),
    .IDX_W        (IDX_W)
  ) u_seed (
    .clk       (clk),
    .rst       (rst),
    .clear_idx (clear_idx),
    .wr_en     (word_accept),
    .word      (cfg_word),
    .seed_hv   (seed_hv),
    .last_word (last_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      seed_hv_valid <= 1'b0;
      seed_loaded   <= 1'b0;
    end else begin
      seed_hv_valid <= 1'b0;
      unique case (state)
        ST_IDLE:   if (cfg_start) state <= ST_LOAD;
        ST_LOAD:   if (word_accept && last_word) begin
                     state         <= ST_COMMIT;
                     seed_hv_valid <= 1'b1;
                     seed_loaded   <= 1'b1;
                   end
        ST_COMMIT: state <= ST_RUN;
        ST_RUN:    if (cfg_start) state <= ST_DRAIN;
        ST_DRAIN:  if (inflight == '0) state <= ST_LOAD;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // A timeout abandons every outstanding sample so a pending drain can finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= '0;
      to_cnt       <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (start_clears) begin
        timeout_err  <= 1'b0;
        protocol_err <= 1'b0;
      end
      if (dec && inflight == '0)
        protocol_err <= 1'b1;
      if (to_fire) begin
        inflight    <= '0;
        to_cnt      <= '0;
        timeout_err <= 1'b1;
      end else begin
        if (inc && !dec)
          inflight <= inflight + 1'b1;
        else if (dec && !inc && inflight != '0)
          inflight <= inflight - 1'b1;
        to_cnt <= (inflight == '0 || dec) ? '0 : to_cnt + 1'b1;
      end
    end
  end

endmodule
